// File: rtl/multi_pulse_gen.sv
// Multi-channel pulse generator: each channel runs its own IDLE/HIGH/LOW FSM
// on a latched copy of width/period/count, in one-shot or periodic mode.
module multi_pulse_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] start,
  input  logic [CHANNELS-1:0] stop,
  input  logic                mode,
  input  logic [CNT_W-1:0]    width,
  input  logic [CNT_W-1:0]    period,
  input  logic [CNT_W-1:0]    count,
  output logic [CHANNELS-1:0] signal,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  // state | meaning
  // IDLE  | waiting for start; the done strobe is presented while here
  // HIGH  | pulse high, cnt holds remaining high cycles (down-counter)
  // LOW   | periodic gap, cnt holds remaining low cycles (down-counter)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] pulses, pulses_nxt;
    logic [CNT_W-1:0] width_l, width_l_nxt;
    logic [CNT_W-1:0] period_l, period_l_nxt;
    logic [CNT_W-1:0] count_l, count_l_nxt;
    logic             mode_l, mode_l_nxt;
    logic             done_q, done_nxt;
    logic             sig_q;
    logic [CNT_W-1:0] low_len;

    // A gap is never shorter than one cycle, so period<=width yields width+1.
    always_comb low_len = (period_l > width_l) ? period_l - width_l : ONE;

    always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      pulses_nxt   = pulses;
      width_l_nxt  = width_l;
      period_l_nxt = period_l;
      count_l_nxt  = count_l;
      mode_l_nxt   = mode_l;
      done_nxt     = 1'b0;
      case (state)
        IDLE: begin
          if (start[i] && !stop[i]) begin
            mode_l_nxt   = mode;
            width_l_nxt  = width;
            period_l_nxt = period;
            count_l_nxt  = count;
            pulses_nxt   = count;
            if (width != '0) begin
              state_nxt = HIGH;
              cnt_nxt   = width;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        HIGH: begin
          if (stop[i]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt <= ONE) begin
            if (!mode_l || (count_l != '0 && pulses == ONE)) begin
              state_nxt  = IDLE;
              cnt_nxt    = '0;
              pulses_nxt = '0;
              done_nxt   = 1'b1;
            end else begin
              state_nxt = LOW;
              cnt_nxt   = low_len;
              if (count_l != '0) pulses_nxt = pulses - ONE;
            end
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
        LOW: begin
          if (stop[i]) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt <= ONE) begin
            state_nxt = HIGH;
            cnt_nxt   = width_l;
          end else begin
            cnt_nxt = cnt - ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        state    <= IDLE;
        cnt      <= '0;
        pulses   <= '0;
        width_l  <= '0;
        period_l <= '0;
        count_l  <= '0;
        mode_l   <= 1'b0;
        done_q   <= 1'b0;
        sig_q    <= 1'b0;
      end else begin
        state    <= state_nxt;
        cnt      <= cnt_nxt;
        pulses   <= pulses_nxt;
        width_l  <= width_l_nxt;
        period_l <= period_l_nxt;
        count_l  <= count_l_nxt;
        mode_l   <= mode_l_nxt;
        done_q   <= done_nxt;
        sig_q    <= (state_nxt == HIGH);
      end
    end

    assign signal[i] = sig_q;
    assign busy[i]   = (state != IDLE);
    assign done[i]   = done_q;
  end

endmodule

// File: doc/multi_pulse_gen.md
MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

Interface
REQ-001 The block SHALL take parameter CHANNELS, default 4: number of independent pulse channels.
REQ-002 The block SHALL take parameter CNT_W, default 8: width of the width, period and count fields.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port start, input, CHANNELS bits: per-channel start request, level sampled each edge.
REQ-006 The block SHALL have port stop, input, CHANNELS bits: per-channel abort request.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = periodic.
REQ-008 The block SHALL have port width, input, CNT_W bits: pulse high time in clock cycles.
REQ-009 The block SHALL have port period, input, CNT_W bits: rising-edge-to-rising-edge spacing in cycles (periodic mode).
REQ-010 The block SHALL have port count, input, CNT_W bits: number of pulses in periodic mode; 0 = free-run.
REQ-011 The block SHALL have port signal, output, CHANNELS bits: registered pulse outputs.
REQ-012 The block SHALL have port busy, output, CHANNELS bits: channel not IDLE.
REQ-013 The block SHALL have port done, output, CHANNELS bits: one-cycle completion strobe.

Function
REQ-014 Each channel SHALL run a private FSM with states IDLE, HIGH, LOW; channels SHALL share only the mode, width, period and count inputs.
REQ-015 In IDLE with start[i]=1 and stop[i]=0, channel i SHALL latch mode, width, period and count at that edge; later input changes SHALL NOT affect the run.
REQ-016 After acceptance, with width>0, the channel SHALL enter HIGH: signal[i]=1 from the next cycle for exactly width cycles (latency 1 cycle).
REQ-017 With latched width=0, the channel SHALL NOT enter HIGH: signal[i] stays 0, and done[i]=1 for the cycle after acceptance, then IDLE.
REQ-018 In one-shot mode, after HIGH the channel SHALL return to IDLE; done[i]=1 for exactly the first cycle signal[i] is 0 again.
REQ-019 In periodic mode, the channel SHALL hold LOW for period-width cycles, then re-enter HIGH, giving a period of exactly period cycles.
REQ-020 When period<=width, LOW SHALL last 1 cycle, giving an effective period of width+1.
REQ-021 In periodic mode with count=N>0, the channel SHALL emit exactly N pulses; after the Nth HIGH it SHALL go to IDLE with no trailing LOW, and done[i] SHALL behave as in REQ-018.
REQ-022 With count=0 in periodic mode, the channel SHALL run until stop or reset; done[i] SHALL never assert.
REQ-023 stop[i]=1 in HIGH or LOW SHALL force IDLE at that edge: signal[i]=0 and busy[i]=0 from the next cycle, and done[i] SHALL stay 0.
REQ-024 start[i] and stop[i] both set in IDLE: stop SHALL win and nothing is accepted.
REQ-025 start[i] while busy SHALL be ignored, with no restart and no effect on counters.
REQ-026 busy[i] SHALL be 1 in HIGH and LOW, and 0 in IDLE, including the done cycle.
REQ-027 Internal cycle and pulse counters SHALL be CNT_W bits and SHALL NOT wrap: width=2^CNT_W-1 gives exactly that many high cycles.
REQ-028 Channels SHALL be fully independent: simultaneous starts on different channels SHALL each produce correct timing.

Reset
REQ-029 At any edge with reset=1, all channels SHALL enter IDLE with signal=0, busy=0, done=0, and latched config and counters at 0.
REQ-030 reset SHALL override start and stop, including reset asserted mid-pulse: signal drops in the following cycle.
REQ-031 The first start is accepted at the first edge where reset=0.

Verification
REQ-032 Reset: reset=1 for 2 cycles with start all-ones -> signal, busy and done all 0; after release with start held, every channel starts 1 cycle later.
REQ-033 One-shot: mode=0, width=6, start[0] for 1 cycle -> signal[0] high exactly 6 cycles, busy[0] high 6 cycles, done[0] high 1 cycle at the fall; other channels stay 0.
REQ-034 Periodic counted: mode=1, width=3, period=8, count=4 on channel 1 -> 4 pulses with rising edges 8 cycles apart, busy[1] high 27 cycles, done[1] once after the 4th fall.
REQ-035 Free-run abort: mode=1, width=2, period=5, count=0, then stop[2] at cycle 20 -> signal[2] and busy[2] are 0 the next cycle, and done[2] never asserts.
REQ-036 Edge cases: width=0 gives no pulse and done 1 cycle after start; width=5, period=5 gives a period of 6; start re-pulsed mid-run is ignored; a config change mid-run is ignored.
REQ-037 Concurrency: start[3] with width=4 and start[0] with width=9 on the same edge -> both pulses begin on the same cycle and end 4 and 9 cycles later.
